// File: rtl/matrix_pkg.sv
// Shared helpers for the matrix serializer: index widths, FSM states, index constants.
// Emission order is selected in matrix_serialize_m by MATRIX_SERIALIZE_COL_MAJOR_EN.
package matrix_pkg;

    typedef enum logic {
        ST_EMPTY,
        ST_SEND
    } state_t;

    // Wide enough to carry any index constant before it is sized to RW/CW.
    typedef logic [31:0] idx_t;

    // An index must be at least one bit wide, even for a single row/column.
    function automatic int idx_width(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

    function automatic idx_t last_idx(input int n);
        return idx_t'(n - 1);
    endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Two-level wrapping index counter: the inner index runs 0..INNER_N-1, then the outer one steps.
// clear has priority over advance so a fresh matrix always starts at (0,0).
module matrix_index_counter
    import matrix_pkg::*;
#(
    parameter int INNER_N = 1,
    parameter int OUTER_N = 1,
    parameter int IW      = idx_width(INNER_N),
    parameter int OW      = idx_width(OUTER_N)
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [IW-1:0] inner,
    output logic [OW-1:0] outer,
    output logic          inner_last,
    output logic          outer_last
);

    localparam logic [IW-1:0] INNER_MAX = IW'(last_idx(INNER_N));
    localparam logic [OW-1:0] OUTER_MAX = OW'(last_idx(OUTER_N));

    assign inner_last = (inner == INNER_MAX);
    assign outer_last = (outer == OUTER_MAX);

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            inner <= '0;
            outer <= '0;
        end else if (advance) begin
            if (inner_last) begin
                inner <= '0;
                outer <= outer_last ? '0 : outer + OW'(1);
            end else begin
                inner <= inner + IW'(1);
            end
        end
    end

endmodule

// File: rtl/matrix_serialize_m.sv
// Matrix-to-stream serializer: one valid/ready capture of an R x C matrix, one element per beat.
// Define MATRIX_SERIALIZE_COL_MAJOR_EN for column-major emission; default is row-major.
module matrix_serialize_m
    import matrix_pkg::*;
#(
    parameter  int WIDTH = 1,
    parameter  int R     = 1,
    parameter  int C     = 1,
    localparam int RW    = idx_width(R),
    localparam int CW    = idx_width(C)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data [R][C],
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    out_row,
    output logic [CW-1:0]    out_col,
    output logic             out_row_last,
    output logic             out_last
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] mat_buf [R][C];
    logic             in_hs;
    logic             out_hs;
    logic             inner_last;
    logic             outer_last;

    assign out_valid = (state == ST_SEND);
    assign out_hs    = out_valid && out_ready;
    // A new matrix may land in the same cycle the last element leaves: no bubble.
    assign in_ready  = !rst && ((state == ST_EMPTY) || (out_hs && out_last));
    assign in_hs     = in_valid && in_ready;

`ifdef MATRIX_SERIALIZE_COL_MAJOR_EN
    matrix_index_counter #(
        .INNER_N (R),
        .OUTER_N (C),
        .IW      (RW),
        .OW      (CW)
    ) u_index (
        .clk        (clk),
        .rst        (rst),
        .clear      (in_hs),
        .advance    (out_hs),
        .inner      (out_row),
        .outer      (out_col),
        .inner_last (inner_last),
        .outer_last (outer_last)
    );
`else
    matrix_index_counter #(
        .INNER_N (C),
        .OUTER_N (R),
        .IW      (CW),
        .OW      (RW)
    ) u_index (
        .clk        (clk),
        .rst        (rst),
        .clear      (in_hs),
        .advance    (out_hs),
        .inner      (out_col),
        .outer      (out_row),
        .inner_last (inner_last),
        .outer_last (outer_last)
    );
`endif

    // The inner index ends a row (row-major) or a column (column-major) in either build.
    assign out_row_last = out_valid && inner_last;
    assign out_last     = out_valid && inner_last && outer_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (in_hs) begin
            state_nxt = ST_SEND;
        end else if (out_hs && out_last) begin
            state_nxt = ST_EMPTY;
        end
    end

    // NOTE: the matrix buffer is plain storage with no reset; it is only read while
    // out_valid is high, which requires a capture after reset.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            mat_buf <= in_data;
        end
    end

    // Element select by comparison keeps the mux legal for degenerate 1-row/1-column sizes.
    always_comb begin
        out_data = '0;
        for (int r = 0; r < R; r++) begin
            for (int c = 0; c < C; c++) begin
                if (out_row == RW'(r) && out_col == CW'(c)) begin
                    out_data = mat_buf[r][c];
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_serialize_m.sv
// Self-checking bench for matrix_serialize_m: a 2x3 instance and a 1x1 instance against a beat-queue model.
// Honours MATRIX_SERIALIZE_COL_MAJOR_EN for the expected emission order.
module tb_matrix_serialize_m;

    localparam int NR = 2;
    localparam int NC = 3;

    typedef logic [7:0] mat_t [NR][NC];
    typedef logic [7:0] one_t [1][1];

    typedef struct {
        logic [7:0] d;
        int         r;
        int         c;
        bit         rl;
        bit         l;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    mat_t       in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [0:0] out_row;
    logic [1:0] out_col;
    logic       out_row_last;
    logic       out_last;

    one_t       in1_data;
    logic       in1_valid;
    logic       in1_ready;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [0:0] out1_row;
    logic [0:0] out1_col;
    logic       out1_row_last;
    logic       out1_last;

    beat_t q  [$];
    beat_t q1 [$];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    matrix_serialize_m #(.WIDTH(8), .R(NR), .C(NC)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_row_last (out_row_last),
        .out_last     (out_last)
    );

    matrix_serialize_m #(.WIDTH(8), .R(1), .C(1)) dut1 (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in1_data),
        .in_valid     (in1_valid),
        .in_ready     (in1_ready),
        .out_data     (out1_data),
        .out_valid    (out1_valid),
        .out_ready    (out1_ready),
        .out_row      (out1_row),
        .out_col      (out1_col),
        .out_row_last (out1_row_last),
        .out_last     (out1_last)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected beats of one matrix, enumerated in emission order.
    task automatic push_matrix(input mat_t m);
`ifdef MATRIX_SERIALIZE_COL_MAJOR_EN
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++)
                q.push_back('{m[r][c], r, c, r == NR - 1, r == NR - 1 && c == NC - 1});
`else
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                q.push_back('{m[r][c], r, c, c == NC - 1, r == NR - 1 && c == NC - 1});
`endif
    endtask

    task automatic check_beat(input string tag, input beat_t b, input logic [7:0] d,
                              input logic [31:0] r, input logic [31:0] c,
                              input logic rl, input logic l);
        check({tag, ".data"}, 32'(d), 32'(b.d));
        check({tag, ".row"}, r, 32'(b.r));
        check({tag, ".col"}, c, 32'(b.c));
        check({tag, ".row_last"}, 32'(rl), 32'(b.rl));
        check({tag, ".last"}, 32'(l), 32'(b.l));
    endtask

    // One clock: compare both DUTs to the model at negedge, update the model, then
    // return 1 ns after the next posedge so the caller can drive new inputs.
    task automatic cycle();
        bit exp_v, exp_rdy, exp_v1, exp_rdy1;
        @(negedge clk);
        exp_v    = (q.size() > 0);
        exp_rdy  = !rst && (q.size() == 0 || (q.size() == 1 && out_ready));
        exp_v1   = (q1.size() > 0);
        exp_rdy1 = !rst && (q1.size() == 0 || (q1.size() == 1 && out1_ready));
        check("m23.out_valid", 32'(out_valid), 32'(exp_v));
        check("m23.in_ready", 32'(in_ready), 32'(exp_rdy));
        check("m11.out_valid", 32'(out1_valid), 32'(exp_v1));
        check("m11.in_ready", 32'(in1_ready), 32'(exp_rdy1));
        if (exp_v)
            check_beat("m23", q[0], out_data, 32'(out_row), 32'(out_col), out_row_last, out_last);
        if (exp_v1)
            check_beat("m11", q1[0], out1_data, 32'(out1_row), 32'(out1_col), out1_row_last, out1_last);
        if (rst) begin
            q.delete();
            q1.delete();
        end else begin
            if (exp_v && out_ready) void'(q.pop_front());
            if (in_valid && exp_rdy) push_matrix(in_data);
            if (exp_v1 && out1_ready) void'(q1.pop_front());
            if (in1_valid && exp_rdy1) q1.push_back('{in1_data[0][0], 0, 0, 1'b1, 1'b1});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_matrix(input int base);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                in_data[r][c] = 8'(base + r * NC + c);
    endtask

    task automatic rand_matrix();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                in_data[r][c] = 8'($urandom);
    endtask

    initial begin
        // Reset held three cycles with a matrix already offered.
        rst        = 1'b1;
        set_matrix(1);
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        in1_data[0][0] = 8'h00;
        in1_valid  = 1'b0;
        out1_ready = 1'b1;
        repeat (3) cycle();

        // Release: {{1,2,3},{4,5,6}} accepted, then {{7..12}} queued back-to-back.
        rst = 1'b0;
        cycle();
        set_matrix(7);
        repeat (6) cycle();
        in_valid = 1'b0;
        repeat (7) cycle();

        // Backpressure while element 3 is shown.
        set_matrix(8'h21);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (2) cycle();
        out_ready = 1'b0;
        repeat (4) cycle();
        out_ready = 1'b1;
        repeat (5) cycle();

        // Reset after element 2, then a fresh matrix from (0,0).
        set_matrix(8'h41);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        set_matrix(8'h61);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (7) cycle();

        // 1x1 instance: 0xA5 then 0x5A back-to-back.
        in1_data[0][0] = 8'hA5;
        in1_valid = 1'b1;
        cycle();
        in1_data[0][0] = 8'h5A;
        cycle();
        in1_valid = 1'b0;
        repeat (2) cycle();

        // Random traffic on both instances, then drain.
        for (int i = 0; i < 400; i++) begin
            rand_matrix();
            in_valid       = 1'($urandom_range(0, 1));
            out_ready      = ($urandom_range(0, 3) != 0);
            in1_data[0][0] = 8'($urandom);
            in1_valid      = 1'($urandom_range(0, 1));
            out1_ready     = 1'($urandom_range(0, 1));
            cycle();
        end
        in_valid   = 1'b0;
        in1_valid  = 1'b0;
        out_ready  = 1'b1;
        out1_ready = 1'b1;
        repeat (8) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
